// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the single memory block between
// the CPU controller and an auxiliary requester (loader / DMA). Each request
// runs as ADDR -> XFER -> (WAIT) -> DONE. All outputs come straight from
// flops, computed from the next-state values so that they line up with the
// state they belong to.
module mem_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [15:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_done,
  output logic [15:0] rdata,
  output logic        mem_addr_en,
  output logic [15:0] mem_addr,
  output logic        mem_in_en,
  output logic [15:0] mem_in,
  output logic        mem_out_en,
  input  logic [15:0] mem_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_XFER,
    S_WAIT,
    S_DONE
  } state_t;

  // Number of WAIT cycles after XFER on a read; mem_out_en spans XFER + WAIT.
  localparam logic [1:0] WAIT_CYC = 2'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = CPU, 1 = AUX
  logic        last_q, last_d;     // owner of the most recent grant
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;

  logic        cpu_gnt_q, aux_gnt_q, cpu_done_q, aux_done_q;
  logic        mem_addr_en_q, mem_in_en_q, mem_out_en_q, busy_q;
  logic [15:0] mem_addr_q, mem_in_q;

  logic        any_req;
  logic        win_aux;
  logic        grant;

  // AUX wins if it is alone, or on a tie when the CPU was granted last.
  assign any_req = cpu_req | aux_req;
  assign win_aux = aux_req & (~cpu_req | ~last_q);

  // Next-state logic: sequencing, arbitration and request capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    grant   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) grant = 1'b1;
      end
      S_ADDR: begin
        state_d = S_XFER;
      end
      S_XFER: begin
        if (we_q || READ_LAT <= 1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_CYC;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 2'd1) state_d = S_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_DONE: begin
        // Memory data is valid during DONE; capture it as DONE is left.
        if (!we_q) rdata_d = mem_out;
        if (any_req) grant   = 1'b1;
        else         state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A grant freezes the winner's request; later input changes are ignored.
    if (grant) begin
      state_d = S_ADDR;
      owner_d = win_aux;
      last_d  = win_aux;
      we_d    = win_aux ? aux_we    : cpu_we;
      addr_d  = win_aux ? aux_addr  : cpu_addr;
      wdata_d = win_aux ? aux_wdata : cpu_wdata;
    end
  end

  // State registers and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      we_q          <= 1'b0;
      addr_q        <= 16'h0000;
      wdata_q       <= 16'h0000;
      cnt_q         <= 2'd0;
      rdata_q       <= 16'h0000;
      cpu_gnt_q     <= 1'b0;
      aux_gnt_q     <= 1'b0;
      cpu_done_q    <= 1'b0;
      aux_done_q    <= 1'b0;
      mem_addr_en_q <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_in_en_q   <= 1'b0;
      mem_in_q      <= 16'h0000;
      mem_out_en_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      cpu_gnt_q     <= (state_d != S_IDLE) && !owner_d;
      aux_gnt_q     <= (state_d != S_IDLE) &&  owner_d;
      cpu_done_q    <= (state_d == S_DONE) && !owner_d;
      aux_done_q    <= (state_d == S_DONE) &&  owner_d;
      mem_addr_en_q <= (state_d == S_ADDR);
      mem_addr_q    <= (state_d == S_ADDR) ? addr_d : 16'h0000;
      mem_in_en_q   <= (state_d == S_XFER) && we_d;
      mem_in_q      <= ((state_d == S_XFER) && we_d) ? wdata_d : 16'h0000;
      mem_out_en_q  <= ((state_d == S_XFER) && !we_d) || (state_d == S_WAIT);
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign aux_gnt     = aux_gnt_q;
  assign cpu_done    = cpu_done_q;
  assign aux_done    = aux_done_q;
  assign rdata       = rdata_q;
  assign mem_addr_en = mem_addr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_in_en   = mem_in_en_q;
  assign mem_in      = mem_in_q;
  assign mem_out_en  = mem_out_en_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-timeline model (cycle offset within
// each transaction) checked every cycle, a simple memory device driving
// mem_out with READ_LAT latency, and hand-computed literal checks.
module tb_mem_arbiter;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_r, aux_req_r;
  logic        cpu_req, aux_req;
  logic        cpu_we, aux_we;
  logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic        cpu_gnt, cpu_done, aux_gnt, aux_done;
  logic [15:0] rdata;
  logic        mem_addr_en, mem_in_en, mem_out_en, busy;
  logic [15:0] mem_addr, mem_in, mem_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Requesters drop req combinationally on their done pulse.
  assign cpu_req = cpu_req_r & ~cpu_done;
  assign aux_req = aux_req_r & ~aux_done;

  mem_arbiter #(.READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_done(aux_done),
    .rdata(rdata),
    .mem_addr_en(mem_addr_en), .mem_addr(mem_addr),
    .mem_in_en(mem_in_en), .mem_in(mem_in),
    .mem_out_en(mem_out_en), .mem_out(mem_out),
    .busy(busy)
  );

  // Memory device: latched address, write on mem_in_en, read data RL cycles after mem_out_en.
  logic [15:0] dev_mem [0:255];
  logic [15:0] dev_addr;
  logic [15:0] rd_pipe [0:2];
  always @(posedge clk) begin
    if (mem_addr_en) dev_addr <= mem_addr;
    if (mem_in_en) dev_mem[dev_addr[7:0]] <= mem_in;
    rd_pipe[0] <= mem_out_en ? dev_mem[dev_addr[7:0]] : 16'h0000;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign mem_out = rd_pipe[RL-1];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one transaction in flight, k = cycle offset (1 = ADDR), len = DONE offset.
  bit          m_valid = 1'b0;
  bit          m_active, m_owner, m_we, m_last;
  logic [15:0] m_addr, m_wdata, m_rdata;
  int          m_k, m_len;
  logic [15:0] shadow [0:255];
  bit          e_done, ce, ae;
  bit          rec_en = 1'b0;
  bit          gq[$];

  always @(negedge clk) begin
    if (m_valid) begin
      e_done = m_active && (m_k == m_len);
      chk1("busy", busy, m_active);
      chk1("cpu_gnt", cpu_gnt, m_active && !m_owner);
      chk1("aux_gnt", aux_gnt, m_active && m_owner);
      chk1("cpu_done", cpu_done, e_done && !m_owner);
      chk1("aux_done", aux_done, e_done && m_owner);
      chk1("mem_addr_en", mem_addr_en, m_active && m_k == 1);
      chk16("mem_addr", mem_addr, (m_active && m_k == 1) ? m_addr : 16'h0000);
      chk1("mem_in_en", mem_in_en, m_active && m_we && m_k == 2);
      chk16("mem_in", mem_in, (m_active && m_we && m_k == 2) ? m_wdata : 16'h0000);
      chk1("mem_out_en", mem_out_en, m_active && !m_we && m_k >= 2 && m_k <= 1 + RL);
      chk16("rdata", rdata, m_rdata);
    end
    if (rec_en && mem_addr_en) gq.push_back(aux_gnt);

    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_owner  = 1'b0;
      m_we     = 1'b0;
      m_last   = 1'b1;
      m_addr   = 16'h0000;
      m_wdata  = 16'h0000;
      m_rdata  = 16'h0000;
      m_k      = 0;
      m_len    = 0;
    end else if (m_valid) begin
      e_done = m_active && (m_k == m_len);
      ce = cpu_req_r && !(e_done && !m_owner);
      ae = aux_req_r && !(e_done && m_owner);
      if (!m_active || e_done) begin
        if (m_active) begin
          if (m_we) shadow[m_addr[7:0]] = m_wdata;
          else      m_rdata = shadow[m_addr[7:0]];
          $display("txn %s %s addr=%h data=%h", m_owner ? "AUX" : "CPU",
                   m_we ? "WR" : "RD", m_addr, m_we ? m_wdata : m_rdata);
        end
        if (ce || ae) begin
          m_owner  = ae && (!ce || !m_last);
          m_last   = m_owner;
          m_we     = m_owner ? aux_we    : cpu_we;
          m_addr   = m_owner ? aux_addr  : cpu_addr;
          m_wdata  = m_owner ? aux_wdata : cpu_wdata;
          m_active = 1'b1;
          m_k      = 1;
          m_len    = m_we ? 3 : 2 + RL;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_aux, input string name);
    int b = 0;
    while (!(is_aux ? aux_done : cpu_done) && b < 20) begin
      tick();
      b++;
    end
    chk1(name, is_aux ? aux_done : cpu_done, 1'b1);
  endtask

  int cnt_done, budget;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 16'h0000;
      shadow[i]  = 16'h0000;
    end
    for (int i = 0; i < 3; i++) rd_pipe[i] = 16'h0000;
    dev_addr  = 16'h0000;
    rst       = 1'b1;
    cpu_req_r = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    aux_req_r = 1'b1; aux_we = 1'b0; aux_addr = 16'h0010; aux_wdata = 16'h0000;

    // Reset with both requests high.
    repeat (3) tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_aux_gnt", aux_gnt, 1'b0);
    rst = 1'b0;                                   // cycle T (IDLE)
    tick(); chk1("w_gnt", cpu_gnt, 1'b1); chk1("w_aux_gnt", aux_gnt, 1'b0);
            chk1("w_addr_en", mem_addr_en, 1'b1); chk16("w_addr", mem_addr, 16'h0010);
    tick(); chk1("w_in_en", mem_in_en, 1'b1); chk16("w_in", mem_in, 16'hBEEF);
    tick(); chk1("w_done", cpu_done, 1'b1);        // T+3
    tick(); chk1("r_gnt", aux_gnt, 1'b1); chk1("r_cpu_gnt", cpu_gnt, 1'b0);
            cpu_req_r = 1'b0;
    tick(); chk1("r_oe1", mem_out_en, 1'b1);
    tick(); chk1("r_oe2", mem_out_en, 1'b1);
    tick(); chk1("r_done", aux_done, 1'b1); aux_req_r = 1'b0;
    tick(); chk16("r_rdata", rdata, 16'hBEEF); chk1("r_idle", busy, 1'b0);

    // Both requesters continuously issuing writes.
    cpu_addr = 16'h0020; cpu_wdata = 16'h1111;
    aux_we = 1'b1; aux_addr = 16'h0021; aux_wdata = 16'h2222;
    rec_en = 1'b1; cpu_req_r = 1'b1; aux_req_r = 1'b1;
    cnt_done = 0; budget = 0;
    while (cnt_done < 6 && budget < 60) begin
      tick();
      budget++;
      if (cpu_done || aux_done) cnt_done++;
    end
    cpu_req_r = 1'b0; aux_req_r = 1'b0;
    chk16("alt_count", 16'(cnt_done), 16'd6);
    chk16("alt_cycles", 16'(budget), 16'd18);
    tick();
    rec_en = 1'b0;
    chk16("alt_grants", 16'(gq.size()), 16'd6);
    for (int i = 0; i < gq.size() && i < 6; i++) chk1("alt_order", gq[i], (i % 2) == 1);
    chk1("alt_idle", busy, 1'b0);

    // Address change and req drop during XFER.
    cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'hCAFE; cpu_req_r = 1'b1;
    tick(); chk16("chg_addr", mem_addr, 16'h0030);
    tick(); chk16("chg_in", mem_in, 16'hCAFE);
            cpu_addr = 16'h0031; cpu_wdata = 16'h0000; cpu_req_r = 1'b0;
    tick(); chk1("chg_done", cpu_done, 1'b1);
    tick(); chk1("chg_no_regrant", cpu_gnt, 1'b0); chk1("chg_idle", busy, 1'b0);

    // Reset during the WAIT cycle of a read.
    aux_we = 1'b0; aux_addr = 16'h0030; aux_req_r = 1'b1;
    tick(); tick(); tick();
    chk1("wait_oe", mem_out_en, 1'b1);
    rst = 1'b1; aux_req_r = 1'b0;
    tick(); chk1("rw_busy", busy, 1'b0); chk1("rw_done", aux_done, 1'b0);
            chk16("rw_rdata", rdata, 16'h0000);
    rst = 1'b0;
    tick(); chk1("rw_no_done", aux_done, 1'b0);

    // Clean restart: read back the original-address write, then the ignored one.
    cpu_we = 1'b0; cpu_addr = 16'h0030; cpu_req_r = 1'b1;
    wait_done(1'b0, "rd30_timeout");
    cpu_req_r = 1'b0;
    tick(); chk16("rd30", rdata, 16'hCAFE);
    aux_we = 1'b0; aux_addr = 16'h0031; aux_req_r = 1'b1;
    wait_done(1'b1, "rd31_timeout");
    aux_req_r = 1'b0;
    tick(); chk16("rd31", rdata, 16'h0000);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
